// File: rtl/fp16_div_pkg.sv
// Shared types and constants for FP16 units that time-share a single divider.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fp16_div_pkg;

   localparam int          FP16_W             = 16;
   localparam logic [15:0] FP16_MAX_FINITE    = 16'h7BFF;
   localparam logic [15:0] FP16_ZERO          = 16'h0000;

   // Must stay above the divider's worst-case latency (about 40 cycles).
   localparam int          DEF_TIMEOUT_CYCLES = 63;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

endpackage

// File: rtl/fp16_rr_pick.sv
// Rotating-priority picker: first set request at or above ptr, wrapping to 0.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the pick is actually granted.
module fp16_rr_pick #(
   parameter int N    = 4,
   parameter int ID_W = $clog2(N)
) (
   input  logic [N-1:0]    req,
   input  logic [ID_W-1:0] ptr,
   output logic [N-1:0]    grant,
   output logic [ID_W-1:0] grant_idx,
   output logic            any_valid
);

   logic            hi_hit;
   logic            lo_hit;
   logic [ID_W-1:0] hi_idx;
   logic [ID_W-1:0] lo_idx;

   // Lowest request at/above ptr (hi) and lowest request below ptr (lo, the wrap case).
   always_comb begin
      hi_hit = 1'b0;
      lo_hit = 1'b0;
      hi_idx = '0;
      lo_idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            if (ID_W'(i) >= ptr) begin
               hi_hit = 1'b1;
               hi_idx = ID_W'(i);
            end else begin
               lo_hit = 1'b1;
               lo_idx = ID_W'(i);
            end
         end
      end
   end

   // Requests at/above the pointer outrank wrapped ones; grant is one-hot of the pick.
   always_comb begin
      grant_idx        = hi_hit ? hi_idx : lo_idx;
      any_valid        = hi_hit | lo_hit;
      grant            = '0;
      grant[grant_idx] = any_valid;
   end

endmodule

// File: rtl/fp16_div_arbiter.sv
// Round-robin share of one iterative FP16 divider; one operation in flight, watchdog abort.
// Latency: grant -> ISSUE -> divider latency (or TIMEOUT_CYCLES) -> one-cycle response pulse.
// Backpressure: req_ready only in IDLE with div_idle high; responses cannot be stalled.
module fp16_div_arbiter
   import fp16_div_pkg::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   parameter int ID_W           = $clog2(NUM_REQ)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_REQ-1:0]       req_valid,
   output logic [NUM_REQ-1:0]       req_ready,
   input  logic [16*NUM_REQ-1:0]    req_dividend,
   input  logic [16*NUM_REQ-1:0]    req_divisor,
   output logic [NUM_REQ-1:0]       resp_valid,
   output logic [15:0]              resp_data,
   output logic [ID_W-1:0]          resp_id,
   output logic                     resp_err,
   output logic                     timeout_sticky,
   output logic                     busy,
   output logic [15:0]              div_dividend,
   output logic [15:0]              div_divisor,
   output logic                     div_input_valid,
   input  logic [15:0]              div_q,
   input  logic                     div_update,
   input  logic                     div_idle
);

   localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
   // WAIT lasts TIMEOUT_CYCLES-1 cycles, so the response lands TIMEOUT_CYCLES after ISSUE.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 2);

   state_t              state;
   state_t              state_nxt;
   logic [ID_W-1:0]     rr_ptr;
   logic [ID_W-1:0]     id_r;
   logic [15:0]         dividend_r;
   logic [15:0]         divisor_r;
   logic [15:0]         data_r;
   logic                err_r;
   logic                sticky_r;
   logic [CNT_W-1:0]    wd_cnt;

   logic [NUM_REQ-1:0]  pick_gnt;
   logic [ID_W-1:0]     pick_idx;
   logic                pick_any;
   logic [15:0]         sel_dividend;
   logic [15:0]         sel_divisor;
   logic                grant_go;
   logic                wd_expire;

   fp16_rr_pick #(
      .N    (NUM_REQ),
      .ID_W (ID_W)
   ) u_pick (
      .req       (req_valid),
      .ptr       (rr_ptr),
      .grant     (pick_gnt),
      .grant_idx (pick_idx),
      .any_valid (pick_any)
   );

   assign grant_go  = (state == IDLE) && div_idle && pick_any;
   assign wd_expire = (wd_cnt == CNT_LAST);

   // Select the winner's operand slices for capture at grant.
   always_comb begin
      sel_dividend = FP16_ZERO;
      sel_divisor  = FP16_ZERO;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (pick_gnt[i]) begin
            sel_dividend = req_dividend[FP16_W*i +: FP16_W];
            sel_divisor  = req_divisor[FP16_W*i +: FP16_W];
         end
      end
   end

   // State register; reset abandons any in-flight operation without a response.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state: a result pulse beats a simultaneous watchdog expiry.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (grant_go) state_nxt = ISSUE;
         ISSUE:   state_nxt = WAIT;
         WAIT:    if (div_update || wd_expire) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Operand/id capture, watchdog, result capture and pointer advance.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr     <= '0;
         id_r       <= '0;
         dividend_r <= FP16_ZERO;
         divisor_r  <= FP16_ZERO;
         data_r     <= FP16_ZERO;
         err_r      <= 1'b0;
         sticky_r   <= 1'b0;
         wd_cnt     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_go) begin
                  dividend_r <= sel_dividend;
                  divisor_r  <= sel_divisor;
                  id_r       <= pick_idx;
               end
            end
            ISSUE: wd_cnt <= '0;
            WAIT: begin
               wd_cnt <= wd_cnt + 1'b1;
               if (div_update) begin
                  data_r <= div_q;
                  err_r  <= 1'b0;
               end else if (wd_expire) begin
                  data_r   <= FP16_ZERO;
                  err_r    <= 1'b1;
                  sticky_r <= 1'b1;
               end
            end
            RESP: begin
               if (id_r == ID_W'(NUM_REQ - 1)) rr_ptr <= '0;
               else                            rr_ptr <= id_r + 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Outputs decoded from registered state; ready is also masked while rst is high.
   always_comb begin
      req_ready       = '0;
      resp_valid      = '0;
      resp_data       = FP16_ZERO;
      resp_id         = '0;
      resp_err        = 1'b0;
      div_input_valid = 1'b0;
      case (state)
         IDLE:  if (div_idle && !rst) req_ready = pick_gnt;
         ISSUE: div_input_valid = 1'b1;
         RESP: begin
            resp_valid[id_r] = 1'b1;
            resp_data        = data_r;
            resp_id          = id_r;
            resp_err         = err_r;
         end
         default: ;
      endcase
   end

   assign busy           = (state != IDLE);
   assign timeout_sticky = sticky_r;
   assign div_dividend   = dividend_r;
   assign div_divisor    = divisor_r;

endmodule

// File: tb/tb_fp16_div_arbiter.sv
// Scoreboard bench for fp16_div_arbiter with a behavioural divider stub.
// Latency: stub answers LAT+1 cycles after seeing div_input_valid, or never when hung.
// Backpressure: requesters hold req_valid until their handshake.
module tb_fp16_div_arbiter;

   localparam int NUM_REQ = 4;
   localparam int TIMEOUT = 63;
   localparam int ID_W    = 2;
   localparam int LAT     = 40;

   logic                  clk;
   logic                  rst;
   logic [NUM_REQ-1:0]    req_valid;
   logic [NUM_REQ-1:0]    req_ready;
   logic [16*NUM_REQ-1:0] req_dividend;
   logic [16*NUM_REQ-1:0] req_divisor;
   logic [NUM_REQ-1:0]    resp_valid;
   logic [15:0]           resp_data;
   logic [ID_W-1:0]       resp_id;
   logic                  resp_err;
   logic                  timeout_sticky;
   logic                  busy;
   logic [15:0]           div_dividend;
   logic [15:0]           div_divisor;
   logic                  div_input_valid;
   logic [15:0]           div_q;
   logic                  div_update;
   logic                  div_idle;

   typedef struct packed {
      logic [ID_W-1:0] rq;
      logic [15:0]     a;
      logic [15:0]     b;
      logic [15:0]     q;
      logic            err;
   } job_t;

   job_t pend[$];
   job_t sb[$];
   int   glog[$];

   int   checks    = 0;
   int   failures  = 0;
   int   cyc       = 0;
   int   iss_cnt   = 0;
   int   iss_cyc   = 0;
   int   resp_cnt  = 0;
   int   resp_cyc  = 0;

   logic        hang       = 1'b0;
   logic        idle_block = 1'b0;
   logic        st_busy    = 1'b0;
   int          st_cnt     = 0;
   logic [15:0] st_res     = 16'h0;

   fp16_div_arbiter #(
      .NUM_REQ        (NUM_REQ),
      .TIMEOUT_CYCLES (TIMEOUT)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .req_dividend    (req_dividend),
      .req_divisor     (req_divisor),
      .resp_valid      (resp_valid),
      .resp_data       (resp_data),
      .resp_id         (resp_id),
      .resp_err        (resp_err),
      .timeout_sticky  (timeout_sticky),
      .busy            (busy),
      .div_dividend    (div_dividend),
      .div_divisor     (div_divisor),
      .div_input_valid (div_input_valid),
      .div_q           (div_q),
      .div_update      (div_update),
      .div_idle        (div_idle)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Known quotients the stub divider produces (the divider owns FP16 semantics).
   function automatic logic [15:0] stub_div(input logic [15:0] a, input logic [15:0] b);
      case ({a, b})
         32'h4600_4000: return 16'h4200;
         32'h3C00_3C00: return 16'h3C00;
         32'h3C00_4000: return 16'h3800;
         32'h4400_4000: return 16'h4000;
         32'h4000_4400: return 16'h3800;
         32'h3C00_0000: return 16'h7BFF;
         32'h4200_3C00: return 16'h4200;
         default:       return 16'h7E00;
      endcase
   endfunction

   task automatic post(input int rq, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] q, input logic err);
      job_t j;
      j.rq  = ID_W'(rq);
      j.a   = a;
      j.b   = b;
      j.q   = q;
      j.err = err;
      pend.push_back(j);
   endtask

   task automatic stub_step();
      if (rst) begin
         st_busy    = 1'b0;
         div_update = 1'b0;
         div_q      = 16'h0;
      end else begin
         div_update = 1'b0;
         if (st_busy) begin
            if (st_cnt == 0) begin
               div_update = 1'b1;
               div_q      = st_res;
               st_busy    = 1'b0;
            end else begin
               st_cnt--;
            end
         end else if (div_input_valid && !hang) begin
            st_busy = 1'b1;
            st_cnt  = LAT;
            st_res  = stub_div(div_dividend, div_divisor);
         end
      end
      div_idle = hang | (!st_busy && !idle_block && !rst);
   endtask

   task automatic drive_reqs();
      logic hit;
      for (int i = 0; i < NUM_REQ; i++) begin
         hit = 1'b0;
         for (int k = 0; k < pend.size(); k++) begin
            if (!hit && pend[k].rq == ID_W'(i)) begin
               hit = 1'b1;
               req_dividend[16*i +: 16] = pend[k].a;
               req_divisor[16*i +: 16]  = pend[k].b;
            end
         end
         req_valid[i] = hit;
      end
   endtask

   task automatic monitor();
      job_t e;
      int   idx;
      if (div_input_valid) begin
         iss_cnt++;
         iss_cyc = cyc;
      end
      if (req_ready != '0) check("rdy_onehot", $countones(req_ready), 1);
      for (int i = 0; i < NUM_REQ; i++) begin
         if (req_valid[i] && req_ready[i]) begin
            idx = -1;
            for (int k = 0; k < pend.size(); k++)
               if (idx < 0 && pend[k].rq == ID_W'(i)) idx = k;
            glog.push_back(i);
            if (idx >= 0) begin
               sb.push_back(pend[idx]);
               pend.delete(idx);
            end
         end
      end
      if (resp_valid != '0) begin
         resp_cnt++;
         resp_cyc = cyc;
         if (sb.size() == 0) begin
            check("resp_unexp", 32'(resp_valid), 0);
         end else begin
            e = sb.pop_front();
            check("resp_valid", 32'(resp_valid), 32'(1) << e.rq);
            check("resp_id",    32'(resp_id),    32'(e.rq));
            check("resp_data",  32'(resp_data),  32'(e.q));
            check("resp_err",   32'(resp_err),   32'(e.err));
         end
      end
   endtask

   task automatic tick();
      @(negedge clk);
      cyc++;
      stub_step();
      drive_reqs();
      #1;
      monitor();
   endtask

   task automatic wait_done(input string tag);
      for (int n = 0; n < 400 && (pend.size() != 0 || sb.size() != 0 || busy); n++) tick();
      check(tag, 32'(pend.size() + sb.size()), 0);
   endtask

   task automatic check_outs_zero(input string tag);
      check({tag, "_ctl"}, 32'({busy, timeout_sticky, resp_err, div_input_valid,
                                resp_valid, req_ready, resp_id, div_divisor}), 0);
      check({tag, "_dat"}, {resp_data, div_dividend}, 0);
   endtask

   int exp_fair[5] = '{0, 1, 2, 3, 0};

   initial begin
      int g0;
      int i0;
      int r0;
      rst          = 1'b1;
      req_valid    = '0;
      req_dividend = '0;
      req_divisor  = '0;
      div_q        = 16'h0;
      div_update   = 1'b0;
      div_idle     = 1'b0;

      // Reset state
      repeat (3) tick();
      check_outs_zero("rst_outs");
      rst = 1'b0;

      // Fairness: all four requesters valid, requester 0 queues a second job
      g0 = glog.size();
      post(0, 16'h4600, 16'h4000, 16'h4200, 1'b0);
      post(1, 16'h3C00, 16'h3C00, 16'h3C00, 1'b0);
      post(2, 16'h3C00, 16'h4000, 16'h3800, 1'b0);
      post(3, 16'h4400, 16'h4000, 16'h4000, 1'b0);
      post(0, 16'h4000, 16'h4400, 16'h3800, 1'b0);
      wait_done("fair_done");
      for (int k = 0; k < 5; k++) check("fair_grant", glog[g0 + k], exp_fair[k]);

      // Single request with one-cycle issue strobe
      i0 = iss_cnt;
      post(0, 16'h4600, 16'h4000, 16'h4200, 1'b0);
      wait_done("single_done");
      check("single_iss", iss_cnt - i0, 1);

      // Divide by zero: divider saturation passes through
      post(1, 16'h3C00, 16'h0000, 16'h7BFF, 1'b0);
      wait_done("dbz_done");

      // Divider not ready for 5 cycles
      idle_block = 1'b1;
      post(3, 16'h4200, 16'h3C00, 16'h4200, 1'b0);
      for (int k = 0; k < 5; k++) begin
         tick();
         check("nr_ready", 32'(req_ready), 0);
         check("nr_busy", 32'(busy), 0);
      end
      idle_block = 1'b0;
      tick();
      check("nr_grant", 32'(req_ready), 32'h8);
      wait_done("nr_done");

      // Hung divider: watchdog abort then normal service
      hang = 1'b1;
      post(2, 16'h3C00, 16'h4000, 16'h0000, 1'b1);
      wait_done("hang_done");
      check("hang_lat", resp_cyc - iss_cyc, TIMEOUT);
      check("hang_sticky", 32'(timeout_sticky), 1);
      hang = 1'b0;
      post(1, 16'h4600, 16'h4000, 16'h4200, 1'b0);
      wait_done("post_hang_done");
      check("sticky_hold", 32'(timeout_sticky), 1);

      // Reset during WAIT
      post(2, 16'h4600, 16'h4000, 16'h4200, 1'b0);
      i0 = iss_cnt;
      for (int n = 0; n < 50 && iss_cnt == i0; n++) tick();
      check("mrst_issued", iss_cnt - i0, 1);
      repeat (5) tick();
      #2;
      rst = 1'b1;
      #1;
      check_outs_zero("mrst_outs");
      sb.delete();
      pend.delete();
      repeat (3) tick();
      rst = 1'b0;
      r0 = resp_cnt;
      repeat (60) tick();
      check("mrst_noresp", resp_cnt - r0, 0);
      g0 = glog.size();
      post(3, 16'h4400, 16'h4000, 16'h4000, 1'b0);
      post(0, 16'h3C00, 16'h4000, 16'h3800, 1'b0);
      wait_done("mrst_done");
      check("mrst_ngrant", glog.size() - g0, 2);
      if (glog.size() - g0 == 2) begin
         check("mrst_g0", glog[g0], 0);
         check("mrst_g1", glog[g0 + 1], 3);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fp16_div_arbiter.md
Name: fp16_div_arbiter

Overview:
- Shares one iterative FP16 divider among NUM_REQ requesters using round-robin arbitration, one operation in flight at a time.
- Grants a requester, holds its operands, issues a single-cycle start to the divider, then waits for the divider's one-cycle result pulse.
- Returns the quotient to the issuing requester, tagged with its index.
- A watchdog aborts an operation whose result never arrives, so a hung divider cannot deadlock the requesters.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYCLES, 63, cycles in WAIT without a result pulse before abort. Must exceed the divider latency of about 40.
- ID_W, $clog2(NUM_REQ), width of the requester index.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  NUM_REQ  per-requester request.
- req_ready  out  NUM_REQ  one-hot accept; a transfer occurs when req_valid[i] and req_ready[i] are both high.
- req_dividend  in  16*NUM_REQ  packed FP16 dividends; slice i = bits [16i+15:16i].
- req_divisor  in  16*NUM_REQ  packed FP16 divisors.
- resp_valid  out  NUM_REQ  one-hot, one-cycle result pulse.
- resp_data  out  16  quotient; 16'h0000 on abort.
- resp_id  out  ID_W  requester index for resp_data.
- resp_err  out  1  high together with resp_valid when the operation timed out.
- timeout_sticky  out  1  set on any timeout; cleared only by rst.
- busy  out  1  high whenever state != IDLE.
- div_dividend  out  16  to divider data_dividend.
- div_divisor  out  16  to divider data_divisor.
- div_input_valid  out  1  to divider input_valid.
- div_q  in  16  from divider data_q.
- div_update  in  1  from divider output_update.
- div_idle  in  1  from divider idle.

Behaviour:
- Reset state: state=IDLE, rr_ptr=0, operand/id registers 0.
- Reset values of outputs: all outputs 0, including req_ready, resp_*, div_input_valid, busy and timeout_sticky.
- rst may assert in any state. It aborts the in-flight operation with no response. The divider shares rst.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready is combinational: one-hot for the winner, and only when div_idle=1 and a request exists.
  - Winner = first i with req_valid[i], searching upward from rr_ptr with wrap.
  - On grant: register dividend, divisor and id; go to ISSUE.
  - With div_idle=0 (e.g. the divider's first cycles after reset), req_ready=0 and the arbiter stays in IDLE.
- ISSUE:
  - div_input_valid=1 for exactly this one cycle; div_dividend/div_divisor driven from the operand registers.
  - Operand registers stay stable from ISSUE until the next grant.
  - Clear the watchdog counter; go to WAIT.
- WAIT:
  - Counter increments each cycle.
  - div_update=1: capture div_q and set err=0; go to RESP.
  - Counter reaches TIMEOUT_CYCLES-1 without div_update: set err=1, data=0, timeout_sticky=1; go to RESP.
  - div_update and timeout in the same cycle: div_update wins and err=0.
- RESP:
  - Registered outputs for one cycle: resp_valid[id]=1, resp_data, resp_id=id, resp_err=err.
  - rr_ptr = id+1, wrapping at NUM_REQ to 0.
  - Go to IDLE.
  - No response backpressure; requesters must sample the pulse.
- div_update outside WAIT is ignored and does not alter state.
- Minimum turnaround: a new grant can occur the cycle after RESP, provided div_idle=1.
- A request is accepted only on handshake. Requesters may drop req_valid before grant without effect.
- Arithmetic: the arbiter passes operands and results unmodified. All FP16 semantics (saturation to ±0x7BFF, denormals, rounding) belong to the divider.

Decomposition:
- Shared package fp16_div_pkg:
  - state enum {IDLE, ISSUE, WAIT, RESP};
  - FP16 constants FP16_W=16, FP16_MAX_FINITE=16'h7BFF, FP16_ZERO=16'h0000;
  - default TIMEOUT_CYCLES.
- One sub-module, fp16_rr_pick.
  - Purely combinational rotate-priority pick.
  - Inputs: req vector and rr_ptr. Outputs: one-hot grant, grant index and any-valid.
  - Reused by future shared FP16 units.

Test Plan:
- Single request: req 0 sends 0x4600 / 0x4000 (6.0/2.0) → resp_valid[0] with resp_data=0x4200 and resp_err=0; div_input_valid high exactly one cycle.
- Fairness: all four requesters valid continuously, each with distinct operands (e.g. 1.0/2.0 → 0x3800 for req 2) → grants in order 0,1,2,3,0; each resp_id matches its grant.
- Divide by zero: 0x3C00 / 0x0000 from req 1 → resp_data=0x7BFF and resp_err=0 (divider saturation passed through unchanged).
- Hung divider: stub divider holds div_idle=1 and never pulses div_update → resp_valid pulse exactly TIMEOUT_CYCLES cycles after ISSUE, with resp_err=1, resp_data=0x0000 and timeout_sticky=1. The next request is then still serviced.
- Divider not ready: div_idle held 0 for 5 cycles with req_valid[3]=1 → req_ready stays 0, and the grant happens in the first cycle div_idle=1.
- Mid-operation reset: rst asserted during WAIT → all outputs 0 immediately (asynchronous), no resp_valid pulse, rr_ptr=0 after release.
